bitslip_align_ctrl: RTL and testbench

Word-alignment training controller for one 1:10 DDR ISERDES lane of the ADC LVDS receiver. Runs in the CLKDIV (frame) domain, watches the deserialized 10-bit word, and drives the deserializer's RST and BITSLIP inputs until the ADC's fixed training pattern is seen consistently. It then reports LOCKED and keeps monitoring for loss of alignment. One instance per data lane; a frame/FCO lane uses the same block with its own pattern.

---
 rtl/align_pkg.sv | 39 +++
 rtl/align_timer.sv | 29 ++
 rtl/bitslip_align_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_bitslip_align_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/align_pkg.sv
// Shared definitions for the bitslip word-alignment controllers.
// Frame-lane and data-lane instances pull their default pattern and
// timing from here so every lane of the receiver trains the same way.
package align_pkg;

  // Default deserialized word width and ADC training word.
  localparam int              DEF_DATA_WIDTH    = 10;
  localparam logic [9:0]      DEF_PATTERN       = 10'h3E0;

  // Default training timing, all in CLKDIV cycles.
  localparam int              DEF_RST_CYCLES    = 4;
  localparam int              DEF_SETTLE_CYCLES = 8;
  localparam int              DEF_MATCH_COUNT   = 16;
  localparam int              DEF_SLIP_WAIT     = 4;
  localparam int              DEF_MAX_SLIPS     = 20;
  localparam int              DEF_MISS_LIMIT    = 4;

  // Training FSM encoding. Kept as plain constants so the encoding is
  // stable across tools and easy to decode on a logic analyser.
  typedef logic [2:0] align_state_t;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RST_SERDES = 3'd1;
  localparam logic [2:0] ST_SETTLE     = 3'd2;
  localparam logic [2:0] ST_COMPARE    = 3'd3;
  localparam logic [2:0] ST_SLIP       = 3'd4;
  localparam logic [2:0] ST_WAIT_SLIP  = 3'd5;
  localparam logic [2:0] ST_LOCKED     = 3'd6;
  localparam logic [2:0] ST_FAIL       = 3'd7;

  // Largest of three durations; sizes the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/align_timer.sv
// Loadable down-counter used for every fixed-length wait of the
// training sequence. Loading N-1 makes done assert on the N-th cycle
// spent in the waiting state, so the owner leaves after exactly N cycles.
module align_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_reg;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/bitslip_align_ctrl.sv
// Word-alignment training controller for one 1:10 DDR ISERDES lane.
// Resets the deserializer, lets it settle, then compares the received
// word against the training pattern, issuing BITSLIP pulses until the
// pattern is seen MATCH_COUNT times in a row. Once locked, it watches
// for runs of bad words and retrains on its own if MONITOR_EN is set.
module bitslip_align_ctrl
  import align_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PATTERN       = DATA_WIDTH'(DEF_PATTERN),
  parameter int                    RST_CYCLES    = DEF_RST_CYCLES,
  parameter int                    SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int                    MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int                    SLIP_WAIT     = DEF_SLIP_WAIT,
  parameter int                    MAX_SLIPS     = DEF_MAX_SLIPS,
  parameter int                    MISS_LIMIT    = DEF_MISS_LIMIT
) (
  input  logic                             CLKDIV,
  input  logic                             RST_N,
  input  logic [DATA_WIDTH-1:0]            Q,
  input  logic                             START,
  input  logic                             MONITOR_EN,
  output logic                             SERDES_RST,
  output logic                             BITSLIP,
  output logic                             LOCKED,
  output logic                             FAIL,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   SLIP_CNT
);

  localparam int SCW = $clog2(MAX_SLIPS + 1);
  localparam int MCW = $clog2(MATCH_COUNT + 1);
  localparam int MSW = $clog2(MISS_LIMIT + 1);
  localparam int TW  = $clog2(max3(RST_CYCLES, SETTLE_CYCLES, SLIP_WAIT) + 1);

  // Timer reload values: N-1 so the wait lasts exactly N cycles.
  localparam logic [TW-1:0] RST_LOAD    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] SLIP_LOAD   = TW'(SLIP_WAIT - 1);

  localparam logic [SCW-1:0] SLIP_MAX_V  = SCW'(MAX_SLIPS);
  localparam logic [MCW-1:0] MATCH_MAX_V = MCW'(MATCH_COUNT);
  localparam logic [MSW-1:0] MISS_MAX_V  = MSW'(MISS_LIMIT);

  logic [DATA_WIDTH-1:0] q_r_reg;
  logic [DATA_WIDTH-1:0] bit_eq;
  logic                  match;

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic [MCW-1:0]        match_cnt_reg;
  logic [MCW-1:0]        match_cnt_next;
  logic [MSW-1:0]        miss_cnt_reg;
  logic [MSW-1:0]        miss_cnt_next;
  logic [SCW-1:0]        slip_cnt_reg;
  logic [SCW-1:0]        slip_cnt_next;

  logic                  timer_load;
  logic [TW-1:0]         timer_val;
  logic                  timer_done;

  // Capture the deserializer word once so the compare sees a clean,
  // registered value rather than the raw ISERDES output.
  always_ff @(posedge CLKDIV or negedge RST_N) begin
    if (!RST_N) begin
      q_r_reg <= '0;
    end else begin
      q_r_reg <= Q;
    end
  end

  // Per-bit equality against the training word, reduced to one flag.
  genvar gi;
  for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_eq
    assign bit_eq[gi] = (q_r_reg[gi] == PATTERN[gi]);
  end
  assign match = &bit_eq;

  align_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (CLKDIV),
    .rst_n    (RST_N),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Training sequencer: next state, counter updates and timer loads.
  always_comb begin
    state_next     = state_reg;
    match_cnt_next = match_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    slip_cnt_next  = slip_cnt_reg;
    timer_load     = 1'b0;
    timer_val      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          state_next    = ST_RST_SERDES;
          slip_cnt_next = '0;
          timer_load    = 1'b1;
          timer_val     = RST_LOAD;
        end
      end

      ST_RST_SERDES: begin
        if (timer_done) begin
          state_next = ST_SETTLE;
          timer_load = 1'b1;
          timer_val  = SETTLE_LOAD;
        end
      end

      ST_SETTLE: begin
        if (timer_done) begin
          state_next     = ST_COMPARE;
          match_cnt_next = '0;
        end
      end

      ST_COMPARE: begin
        if (match) begin
          // Lock is declared on the same cycle the final match is seen;
          // a bad word on that cycle falls through to the slip branch.
          if ((match_cnt_reg + 1'b1) == MATCH_MAX_V) begin
            state_next     = ST_LOCKED;
            match_cnt_next = '0;
            miss_cnt_next  = '0;
          end else begin
            match_cnt_next = match_cnt_reg + 1'b1;
          end
        end else begin
          match_cnt_next = '0;
          if (slip_cnt_reg == SLIP_MAX_V) begin
            state_next = ST_FAIL;
          end else begin
            state_next    = ST_SLIP;
            slip_cnt_next = slip_cnt_reg + 1'b1;
          end
        end
      end

      ST_SLIP: begin
        // Single-cycle state: BITSLIP is high for exactly this cycle.
        state_next = ST_WAIT_SLIP;
        timer_load = 1'b1;
        timer_val  = SLIP_LOAD;
      end

      ST_WAIT_SLIP: begin
        // The deserializer output is in flux here; q_r is not looked at.
        if (timer_done) begin
          state_next     = ST_COMPARE;
          match_cnt_next = '0;
        end
      end

      ST_LOCKED: begin
        if (START) begin
          state_next    = ST_RST_SERDES;
          slip_cnt_next = '0;
          miss_cnt_next = '0;
          timer_load    = 1'b1;
          timer_val     = RST_LOAD;
        end else if (!MONITOR_EN || match) begin
          miss_cnt_next = '0;
        end else if ((miss_cnt_reg + 1'b1) == MISS_MAX_V) begin
          // Alignment lost: retrain from a fresh deserializer reset.
          state_next    = ST_RST_SERDES;
          slip_cnt_next = '0;
          miss_cnt_next = '0;
          timer_load    = 1'b1;
          timer_val     = RST_LOAD;
        end else begin
          miss_cnt_next = miss_cnt_reg + 1'b1;
        end
      end

      ST_FAIL: begin
        // SLIP_CNT is held so software can read how far training got.
        if (START) begin
          state_next    = ST_RST_SERDES;
          slip_cnt_next = '0;
          timer_load    = 1'b1;
          timer_val     = RST_LOAD;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLKDIV or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      slip_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      match_cnt_reg <= match_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      slip_cnt_reg  <= slip_cnt_next;
    end
  end

  // Outputs decoded from the next state so they are registered yet
  // line up exactly with the state they describe.
  always_ff @(posedge CLKDIV or negedge RST_N) begin
    if (!RST_N) begin
      SERDES_RST <= 1'b0;
      BITSLIP    <= 1'b0;
      LOCKED     <= 1'b0;
      FAIL       <= 1'b0;
    end else begin
      SERDES_RST <= (state_next == ST_RST_SERDES);
      BITSLIP    <= (state_next == ST_SLIP);
      LOCKED     <= (state_next == ST_LOCKED);
      FAIL       <= (state_next == ST_FAIL);
    end
  end

  assign SLIP_CNT = slip_cnt_reg;

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Directed bench for bitslip_align_ctrl: fixed-pattern lock, rotated
// lane that needs three slips, exhausted slips, loss-of-lock monitor,
// near-lock mismatch and asynchronous reset mid-training.
module tb_bitslip_align_ctrl;

  localparam logic [9:0] PAT = 10'h3E0;
  localparam logic [9:0] BAD = 10'h155;

  logic       CLKDIV = 1'b0;
  logic       RST_N  = 1'b0;
  logic [9:0] Q;
  logic       START  = 1'b0;
  logic       MONITOR_EN = 1'b1;
  logic       SERDES_RST;
  logic       BITSLIP;
  logic       LOCKED;
  logic       FAIL;
  logic [4:0] SLIP_CNT;

  int checks = 0;
  int errors = 0;

  // Lane model: either a fixed word, or a rotated pattern that moves one
  // bit position per BITSLIP pulse seen.
  logic       rot_mode   = 1'b0;
  logic [9:0] fixed_word = PAT;
  logic [9:0] rot_start;
  int         rot_base   = 0;

  int cyc           = 0;
  int bitslip_total = 0;
  int last_pulse    = -1000;
  int min_gap       = 1000000;

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < (n % 10); i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  assign Q = rot_mode ? rotl(rot_start, bitslip_total - rot_base) : fixed_word;

  bitslip_align_ctrl dut (
    .CLKDIV     (CLKDIV),
    .RST_N      (RST_N),
    .Q          (Q),
    .START      (START),
    .MONITOR_EN (MONITOR_EN),
    .SERDES_RST (SERDES_RST),
    .BITSLIP    (BITSLIP),
    .LOCKED     (LOCKED),
    .FAIL       (FAIL),
    .SLIP_CNT   (SLIP_CNT)
  );

  always #5 CLKDIV = ~CLKDIV;

  always @(posedge CLKDIV) cyc++;

  // Count slip pulses and the tightest spacing between consecutive ones.
  always @(negedge CLKDIV) begin
    if (BITSLIP === 1'b1) begin
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      bitslip_total++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLKDIV);
  endtask

  // Leaves the bench at the negedge following the edge that sampled START.
  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLKDIV);
    START = 1'b0;
  endtask

  // sel: 0 LOCKED, 1 FAIL, 2 BITSLIP. An expired bound is a failed check.
  task automatic wait_until(input int sel, input int limit, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge CLKDIV);
      case (sel)
        0:       hit = LOCKED;
        1:       hit = FAIL;
        default: hit = BITSLIP;
      endcase
    end
    check(tag, {31'b0, hit}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_serdes_rst"}, {31'b0, SERDES_RST}, 32'd0);
    check({tag, "_bitslip"},    {31'b0, BITSLIP},    32'd0);
    check({tag, "_locked"},     {31'b0, LOCKED},     32'd0);
    check({tag, "_fail"},       {31'b0, FAIL},       32'd0);
    check({tag, "_slip_cnt"},   {27'b0, SLIP_CNT},   32'd0);
  endtask

  logic [9:0] seq [8];
  int         base;

  initial begin
    seq[0] = BAD; seq[1] = BAD; seq[2] = BAD; seq[3] = PAT;
    seq[4] = BAD; seq[5] = BAD; seq[6] = BAD; seq[7] = BAD;
    rot_start = rotl(PAT, 7);   // three left rotations away from PAT

    // ---- Reset state and idle without START
    wait_cycles(3);
    check_all_zero("reset");
    RST_N = 1'b1;
    wait_cycles(3);
    check_all_zero("idle_no_start");
    $display("T1 reset/idle checked");

    // ---- Fixed correct pattern: START edge counts as edge 0
    pulse_start();
    check("rst_edge0", {31'b0, SERDES_RST}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLKDIV);
      check("rst_held", {31'b0, SERDES_RST}, 32'd1);
    end
    @(negedge CLKDIV);
    check("rst_released_edge4", {31'b0, SERDES_RST}, 32'd0);
    wait_cycles(23);                          // after edge 27
    check("not_locked_edge27", {31'b0, LOCKED}, 32'd0);
    @(negedge CLKDIV);                        // after edge 28: 29th edge
    check("locked_edge28", {31'b0, LOCKED}, 32'd1);
    check("fixed_slip_cnt", {27'b0, SLIP_CNT}, 32'd0);
    check("fixed_no_bitslip", bitslip_total, 32'd0);
    $display("T2 fixed-pattern lock checked");

    // ---- Monitor: 3 bad, 1 good, 4 bad -> relock only after the 4th
    MONITOR_EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fixed_word = seq[i];
      @(negedge CLKDIV);
      check("mon_still_locked", {31'b0, LOCKED}, 32'd1);
    end
    fixed_word = PAT;
    @(negedge CLKDIV);
    check("mon_relock_locked", {31'b0, LOCKED}, 32'd0);
    check("mon_relock_rst", {31'b0, SERDES_RST}, 32'd1);
    wait_until(0, 60, "mon_relocked");
    $display("T3 monitor relock checked");

    // ---- Same stimulus with monitoring off: lock held throughout
    MONITOR_EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fixed_word = seq[i];
      @(negedge CLKDIV);
    end
    wait_cycles(4);
    check("nomon_locked", {31'b0, LOCKED}, 32'd1);
    check("nomon_no_rst", {31'b0, SERDES_RST}, 32'd0);
    fixed_word = PAT;
    MONITOR_EN = 1'b1;
    wait_cycles(2);
    $display("T4 monitor-disabled hold checked");

    // ---- Rotated lane: three slips to align
    base     = bitslip_total;
    rot_base = bitslip_total;
    rot_mode = 1'b1;
    pulse_start();
    wait_until(0, 300, "rot_locked");
    check("rot_slip_cnt", {27'b0, SLIP_CNT}, 32'd3);
    check("rot_pulses", bitslip_total - base, 32'd3);
    rot_mode = 1'b0;
    fixed_word = PAT;
    wait_cycles(2);
    $display("T5 rotated-lane lock checked");

    // ---- Never-matching data: slips exhausted -> FAIL
    base = bitslip_total;
    fixed_word = BAD;
    pulse_start();
    wait_until(1, 400, "fail_reached");
    check("fail_slip_cnt", {27'b0, SLIP_CNT}, 32'd20);
    check("fail_not_locked", {31'b0, LOCKED}, 32'd0);
    check("fail_pulses", bitslip_total - base, 32'd20);
    wait_cycles(5);
    check("fail_held", {31'b0, FAIL}, 32'd1);
    check("fail_cnt_held", {27'b0, SLIP_CNT}, 32'd20);
    $display("T6 slip exhaustion checked");

    // ---- START out of FAIL, then 15 matches followed by one mismatch
    base = bitslip_total;
    pulse_start();
    fixed_word = PAT;
    check("restart_rst", {31'b0, SERDES_RST}, 32'd1);
    check("restart_slip_clr", {27'b0, SLIP_CNT}, 32'd0);
    check("restart_fail_clr", {31'b0, FAIL}, 32'd0);
    wait_cycles(26);                          // after edge 26
    fixed_word = BAD;                         // seen by the 16th compare
    @(negedge CLKDIV);                        // after edge 27
    fixed_word = PAT;
    @(negedge CLKDIV);                        // after edge 28
    check("near_no_lock", {31'b0, LOCKED}, 32'd0);
    check("near_bitslip", {31'b0, BITSLIP}, 32'd1);
    check("near_slip_cnt", {27'b0, SLIP_CNT}, 32'd1);
    wait_cycles(20);                          // after edge 48
    check("near_restart_not_yet", {31'b0, LOCKED}, 32'd0);
    @(negedge CLKDIV);                        // after edge 49
    check("near_restart_locked", {31'b0, LOCKED}, 32'd1);
    check("near_one_pulse", bitslip_total - base, 32'd1);
    $display("T7 near-lock mismatch checked");

    // ---- Asynchronous reset during the BITSLIP cycle
    fixed_word = BAD;
    pulse_start();
    wait_until(2, 60, "arst_slip_seen");
    RST_N = 1'b0;
    #1;
    check_all_zero("arst_in_slip");
    wait_cycles(2);
    RST_N = 1'b1;
    wait_cycles(6);
    check_all_zero("arst_slip_idle");

    // ---- Asynchronous reset during WAIT_SLIP
    pulse_start();
    wait_until(2, 60, "arst_wait_slip_seen");
    @(negedge CLKDIV);
    check("arst_wait_cnt", {27'b0, SLIP_CNT}, 32'd1);
    RST_N = 1'b0;
    #1;
    check_all_zero("arst_in_wait");
    wait_cycles(2);
    RST_N = 1'b1;
    wait_cycles(6);
    check_all_zero("arst_wait_idle");
    $display("T8 asynchronous reset checked");

    check("bitslip_gap_ge5", {31'b0, (min_gap >= 5)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
